// File: rtl/crtc_pkg.sv
// CRTC register indices, register-file layout and per-register write masks.
// Pure declarations: no latency, no backpressure.
package crtc_pkg;

    localparam logic [4:0] R_HTOTAL  = 5'd0;
    localparam logic [4:0] R_HDISP   = 5'd1;
    localparam logic [4:0] R_HSYNC   = 5'd2;
    localparam logic [4:0] R_SYNCW   = 5'd3;
    localparam logic [4:0] R_VTOTAL  = 5'd4;
    localparam logic [4:0] R_VADJ    = 5'd5;
    localparam logic [4:0] R_VDISP   = 5'd6;
    localparam logic [4:0] R_VSYNC   = 5'd7;
    localparam logic [4:0] R_MAXSCAN = 5'd9;
    localparam logic [4:0] R_STARTH  = 5'd12;
    localparam logic [4:0] R_STARTL  = 5'd13;

    typedef struct packed {
        logic [7:0] htotal;
        logic [7:0] hdisp;
        logic [7:0] hsync;
        logic [7:0] syncw;
        logic [6:0] vtotal;
        logic [4:0] vadj;
        logic [6:0] vdisp;
        logic [6:0] vsync;
        logic [4:0] maxscan;
        logic [5:0] starth;
        logic [7:0] startl;
    } crtc_regs_t;

    function automatic logic [7:0] reg_mask(input logic [4:0] idx);
        logic [7:0] m;
        m = 8'h00;
        case (idx)
            R_HTOTAL, R_HDISP, R_HSYNC, R_SYNCW, R_STARTL: m = 8'hFF;
            R_VTOTAL, R_VDISP, R_VSYNC:                    m = 8'h7F;
            R_VADJ, R_MAXSCAN:                             m = 8'h1F;
            R_STARTH:                                      m = 8'h3F;
            default:                                       m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/crtc_pulse_timer.sv
// Width-counting pulse: active rises on the tick that carries start, stays for width ticks (0 = 16).
// Latency: active registered on the start tick. Backpressure: none; a start while active retriggers.
module crtc_pulse_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] width,
    output logic       active
);

    logic [3:0] cnt_q, cnt_d;
    logic       active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (tick) begin
            if (start) begin
                active_d = 1'b1;
                // width-1 wraps 0 to 15, which gives the 16-tick pulse for width 0
                cnt_d    = width - 4'd1;
            end else if (active_q) begin
                if (cnt_q == 4'd0) begin
                    active_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/crtc_sync_gen.sv
// 6845-style CRTC: programmable h/v counters producing sync, blank, display enable, ma and ra.
// Latency: all outputs registered on the ce edge that moves the counters. Backpressure: none.
module crtc_sync_gen
    import crtc_pkg::*;
#(
    parameter logic [7:0] DEF_HTOTAL  = 8'd126,
    parameter logic [7:0] DEF_HDISP   = 8'd80,
    parameter logic [7:0] DEF_HSYNC   = 8'd98,
    parameter logic [7:0] DEF_SYNCW   = 8'h39,
    parameter logic [6:0] DEF_VTOTAL  = 7'd24,
    parameter logic [4:0] DEF_VADJ    = 5'd0,
    parameter logic [6:0] DEF_VDISP   = 7'd25,
    parameter logic [6:0] DEF_VSYNC   = 7'd25,
    parameter logic [4:0] DEF_MAXSCAN = 5'd13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        cs,
    input  logic        rs,
    input  logic        we,
    input  logic [7:0]  din,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        de,
    output logic [13:0] ma,
    output logic [4:0]  ra
);

    localparam crtc_regs_t REG_RST = '{
        htotal:  DEF_HTOTAL,
        hdisp:   DEF_HDISP,
        hsync:   DEF_HSYNC,
        syncw:   DEF_SYNCW,
        vtotal:  DEF_VTOTAL,
        vadj:    DEF_VADJ,
        vdisp:   DEF_VDISP,
        vsync:   DEF_VSYNC,
        maxscan: DEF_MAXSCAN,
        starth:  6'd0,
        startl:  8'd0
    };

    crtc_regs_t  regs_q, regs_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  wr_val;

    logic [7:0]  hcnt_q, hcnt_d;
    logic [4:0]  ra_q, ra_d;
    logic [6:0]  row_q, row_d;
    logic        adj_q, adj_d;
    logic [13:0] row_addr_q, row_addr_d;

    logic        hblank_q, hblank_d;
    logic        vblank_q, vblank_d;
    logic        de_q, de_d;
    logic [13:0] ma_q, ma_d;

    logic        line_end, row_end, frame_end;
    logic        hs_start, vs_start;

    // Register file; the counters below only ever read regs_q, so a write
    // landing on a ce cycle is seen from the following ce onwards.
    always_comb begin
        regs_d = regs_q;
        idx_d  = idx_q;
        wr_val = din & reg_mask(idx_q);
        if (cs && we) begin
            if (!rs) begin
                idx_d = din[4:0];
            end else begin
                case (idx_q)
                    R_HTOTAL:  regs_d.htotal  = wr_val;
                    R_HDISP:   regs_d.hdisp   = wr_val;
                    R_HSYNC:   regs_d.hsync   = wr_val;
                    R_SYNCW:   regs_d.syncw   = wr_val;
                    R_VTOTAL:  regs_d.vtotal  = wr_val[6:0];
                    R_VADJ:    regs_d.vadj    = wr_val[4:0];
                    R_VDISP:   regs_d.vdisp   = wr_val[6:0];
                    R_VSYNC:   regs_d.vsync   = wr_val[6:0];
                    R_MAXSCAN: regs_d.maxscan = wr_val[4:0];
                    R_STARTH:  regs_d.starth  = wr_val[5:0];
                    R_STARTL:  regs_d.startl  = wr_val;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        hcnt_d     = hcnt_q;
        ra_d       = ra_q;
        row_d      = row_q;
        adj_d      = adj_q;
        row_addr_d = row_addr_q;
        row_end    = 1'b0;
        frame_end  = 1'b0;
        line_end   = ce && (hcnt_q >= regs_q.htotal);

        if (ce) begin
            hcnt_d = line_end ? 8'd0 : hcnt_q + 8'd1;
        end

        if (line_end) begin
            if (adj_q) begin
                if (({1'b0, ra_q} + 6'd1) >= {1'b0, regs_q.vadj}) begin
                    frame_end = 1'b1;
                end else begin
                    ra_d = ra_q + 5'd1;
                end
            end else if (ra_q >= regs_q.maxscan) begin
                row_end    = 1'b1;
                ra_d       = 5'd0;
                row_addr_d = row_addr_q + {6'd0, regs_q.hdisp};
                if (row_q >= regs_q.vtotal) begin
                    if (regs_q.vadj != 5'd0) begin
                        adj_d = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end else begin
                    row_d = row_q + 7'd1;
                end
            end else begin
                ra_d = ra_q + 5'd1;
            end

            if (frame_end) begin
                row_d      = 7'd0;
                ra_d       = 5'd0;
                adj_d      = 1'b0;
                row_addr_d = {regs_q.starth, regs_q.startl};
            end
        end
    end

    // R7 names the row being entered; the row after the last one (R4+1) is
    // the adjust block if there is one, otherwise the wrap back to row 0.
    always_comb begin
        hs_start = ce && (hcnt_d == regs_q.hsync);
        vs_start = (row_end && (({1'b0, row_q} + 8'd1) == {1'b0, regs_q.vsync}))
                || (frame_end && (regs_q.vsync == 7'd0));
    end

    always_comb begin
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        de_d     = de_q;
        ma_d     = ma_q;
        if (ce) begin
            hblank_d = (hcnt_d >= regs_q.hdisp);
            vblank_d = adj_d || (row_d >= regs_q.vdisp);
            de_d     = !(hblank_d || vblank_d);
            ma_d     = row_addr_d + {6'd0, hcnt_d};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q     <= REG_RST;
            idx_q      <= 5'd0;
            hcnt_q     <= 8'd0;
            ra_q       <= 5'd0;
            row_q      <= 7'd0;
            adj_q      <= 1'b0;
            row_addr_q <= 14'd0;
            hblank_q   <= 1'b0;
            vblank_q   <= 1'b0;
            de_q       <= 1'b1;
            ma_q       <= 14'd0;
        end else begin
            regs_q     <= regs_d;
            idx_q      <= idx_d;
            hcnt_q     <= hcnt_d;
            ra_q       <= ra_d;
            row_q      <= row_d;
            adj_q      <= adj_d;
            row_addr_q <= row_addr_d;
            hblank_q   <= hblank_d;
            vblank_q   <= vblank_d;
            de_q       <= de_d;
            ma_q       <= ma_d;
        end
    end

    crtc_pulse_timer u_hs_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .tick   (ce),
        .start  (hs_start),
        .width  (regs_q.syncw[3:0]),
        .active (hsync)
    );

    crtc_pulse_timer u_vs_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .tick   (line_end),
        .start  (vs_start),
        .width  (regs_q.syncw[7:4]),
        .active (vsync)
    );

    assign hblank = hblank_q;
    assign vblank = vblank_q;
    assign de     = de_q;
    assign ma     = ma_q;
    assign ra     = ra_q;

endmodule
